cmd_frame_parser: RTL and testbench
===================================

// Module: cmd_frame_parser
// PURPOSE
//  Sits between the UART byte receiver and the command executor. Assembles the received
//  byte stream into framed commands [SOF=0xA5, CMD, LEN, PAYLOAD(LEN bytes), CHK], checks
//  length and checksum, and presents each good frame on a valid/ready interface.
//  Malformed, stalled or dropped traffic is reported as a one-cycle error strobe.
// PARAMETERS
//  MAX_LEN         4        max payload bytes per frame (1..16)
//  TIMEOUT_CYCLES  1200000  max clk cycles between bytes inside a frame before abort
//  (derived) LEN_W = $clog2(MAX_LEN+1); TMO_W = $clog2(TIMEOUT_CYCLES+1)
// PORTS
//  clk          in   1            clock
//  reset        in   1            synchronous, active-high reset
//  byte_in      in   8            received byte, qualified by byte_valid
//  byte_valid   in   1            1-cycle strobe per received byte (no backpressure)
//  cmd_valid    out  1            frame available; held until accepted
//  cmd_ready    in   1            consumer accepts frame when cmd_valid && cmd_ready
//  cmd_code     out  8            CMD byte of held frame
//  cmd_len      out  LEN_W        payload length of held frame
//  cmd_payload  out  8*MAX_LEN    payload; byte i at [8i+7:8i], unused bytes zero
//  err_valid    out  1            1-cycle error strobe
//  err_code     out  3            1=bad CHK, 2=LEN>MAX_LEN, 3=timeout, 4=overrun; 0 when idle
// BEHAVIOUR
//  - Reset: state IDLE, all outputs 0, timeout counter 0. Reset mid-frame discards the frame.
//  - States: IDLE, CMD, LEN, PAYLOAD, CHK, HOLD. Transitions advance only on byte_valid,
//    except for timeout and handshake.
//  - IDLE: byte==0xA5 -> CMD; any other byte is silently ignored.
//  - CMD: latch cmd_code, clear payload buffer, chk=byte -> LEN.
//  - LEN: byte>MAX_LEN -> err 2, IDLE. byte==0 -> CHK. Otherwise -> PAYLOAD.
//    In all non-error cases: chk^=byte and idx=0.
//  - PAYLOAD: store byte at idx, chk^=byte, idx++. When idx==len-1 on write -> CHK.
//  - CHK: byte==chk -> HOLD, cmd_valid=1 on the next cycle. Else err 1, IDLE.
//  - HOLD: outputs stable while cmd_valid && !cmd_ready.
//    - Handshake -> IDLE, with cmd_valid=0 on the next cycle.
//    - byte_valid in HOLD without handshake: byte dropped, err 4, stay in HOLD.
//    - byte_valid in the handshake cycle: byte evaluated as in IDLE (SOF check), no err.
//  - Timeout: in CMD/LEN/PAYLOAD/CHK the counter clears on byte_valid and increments otherwise.
//    When it reaches TIMEOUT_CYCLES-1 -> err 3, IDLE. No timeout in IDLE or HOLD.
//  - err_valid/err_code are registered; asserted exactly one cycle after the offending byte or
//    timeout edge; err_code returns to 0 with err_valid.
//  - Latency: last CHK byte strobe -> cmd_valid high 1 cycle later. No other cycle bubbles;
//    back-to-back byte_valid every cycle is supported.
//  - Checksum is 8-bit XOR, no carry. cmd_len is byte_in truncated to LEN_W after range check.
//  - 0xA5 inside CMD/LEN/PAYLOAD/CHK is data, not resync.
// TESTING
//  1 A5 10 02 11 22 21, cmd_ready=1 -> cmd_valid 1 cycle; code 0x10, len 2, payload 0x00002211.
//  2 A5 10 02 11 22 20 -> no cmd_valid; err_valid 1 cycle with err_code 1; next good frame accepted.
//  3 A5 07 05 (MAX_LEN=4) -> err 2 right after LEN. Following bytes 01..05 ignored until next A5.
//  4 A5 33, then idle TIMEOUT_CYCLES cycles (bench TIMEOUT_CYCLES=50) -> err 3 at count 49,
//    state IDLE. Late bytes ignored.
//  5 Good frame A5 31 00 31 with cmd_ready=0; send 2 bytes -> two err 4 strobes, frame held intact.
//    Raise cmd_ready -> accepted once.
//  6 Reset asserted after A5 20 01 -> outputs 0.
//    Then A5 20 01 AA 8B -> code 0x20, len 1, payload 0x000000AA.

Source files
------------

// File: rtl/cmd_frame_parser.sv
// Assembles UART bytes into [A5, CMD, LEN, PAYLOAD, CHK] frames, checks them, and presents good frames.
// Latency: cmd_valid rises 1 cycle after the CHK byte; err strobes 1 cycle after the offending byte or timeout.
// Backpressure: the frame is held while cmd_ready is low; bytes arriving then are dropped with an overrun error.
//
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   byte_in, byte_valid         received byte stream, one strobe per byte, no backpressure
//   cmd_valid, cmd_ready        frame handshake
//   cmd_code, cmd_len           CMD byte and payload length of the held frame
//   cmd_payload                 payload byte i at [8i+7:8i], unused bytes zero
//   err_valid, err_code         one-cycle error strobe: 1 bad CHK, 2 LEN too big, 3 timeout, 4 overrun
module cmd_frame_parser #(
  parameter int MAX_LEN        = 4,
  parameter int TIMEOUT_CYCLES = 1200000,
  localparam int LEN_W         = $clog2(MAX_LEN + 1),
  localparam int TMO_W         = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [7:0]             byte_in,
  input  logic                   byte_valid,
  output logic                   cmd_valid,
  input  logic                   cmd_ready,
  output logic [7:0]             cmd_code,
  output logic [LEN_W-1:0]       cmd_len,
  output logic [8*MAX_LEN-1:0]   cmd_payload,
  output logic                   err_valid,
  output logic [2:0]             err_code
);

  localparam logic [7:0]       SOF       = 8'hA5;
  localparam logic [7:0]       MAX_LEN_B = 8'(MAX_LEN);
  localparam logic [LEN_W-1:0] LEN_ONE   = LEN_W'(1);
  localparam logic [TMO_W-1:0] TMO_ONE   = TMO_W'(1);
  localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);

  localparam logic [2:0] ERR_CHK     = 3'd1;
  localparam logic [2:0] ERR_LEN     = 3'd2;
  localparam logic [2:0] ERR_TIMEOUT = 3'd3;
  localparam logic [2:0] ERR_OVERRUN = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_LEN, S_PAYLOAD, S_CHK, S_HOLD
  } state_t;

  state_t               state_q, state_d;
  logic [7:0]           code_q, code_d;
  logic [LEN_W-1:0]     len_q, len_d;
  logic [LEN_W-1:0]     idx_q, idx_d;
  logic [8*MAX_LEN-1:0] payload_q, payload_d;
  logic [7:0]           chk_q, chk_d;
  logic [TMO_W-1:0]     tmo_q, tmo_d;
  logic                 err_vld_q, err_vld_d;
  logic [2:0]           err_code_q, err_code_d;
  logic                 in_frame;

  // Only the mid-frame states are subject to the inter-byte timeout.
  assign in_frame = (state_q == S_CMD) || (state_q == S_LEN) ||
                    (state_q == S_PAYLOAD) || (state_q == S_CHK);

  always_comb begin
    state_d    = state_q;
    code_d     = code_q;
    len_d      = len_q;
    idx_d      = idx_q;
    payload_d  = payload_q;
    chk_d      = chk_q;
    err_vld_d  = 1'b0;
    err_code_d = 3'd0;

    if (in_frame && !byte_valid) begin
      tmo_d = tmo_q + TMO_ONE;
    end else begin
      tmo_d = '0;
    end

    case (state_q)
      S_IDLE: begin
        if (byte_valid && byte_in == SOF) begin
          state_d = S_CMD;
        end
      end
      S_CMD: begin
        if (byte_valid) begin
          code_d    = byte_in;
          payload_d = '0;
          chk_d     = byte_in;
          state_d   = S_LEN;
        end
      end
      S_LEN: begin
        if (byte_valid) begin
          if (byte_in > MAX_LEN_B) begin
            err_vld_d  = 1'b1;
            err_code_d = ERR_LEN;
            state_d    = S_IDLE;
          end else begin
            len_d   = byte_in[LEN_W-1:0];
            chk_d   = chk_q ^ byte_in;
            idx_d   = '0;
            state_d = (byte_in == 8'd0) ? S_CHK : S_PAYLOAD;
          end
        end
      end
      S_PAYLOAD: begin
        if (byte_valid) begin
          for (int i = 0; i < MAX_LEN; i++) begin
            if (idx_q == LEN_W'(i)) begin
              payload_d[8*i +: 8] = byte_in;
            end
          end
          chk_d = chk_q ^ byte_in;
          idx_d = idx_q + LEN_ONE;
          if (idx_q == len_q - LEN_ONE) begin
            state_d = S_CHK;
          end
        end
      end
      S_CHK: begin
        if (byte_valid) begin
          if (byte_in == chk_q) begin
            state_d = S_HOLD;
          end else begin
            err_vld_d  = 1'b1;
            err_code_d = ERR_CHK;
            state_d    = S_IDLE;
          end
        end
      end
      S_HOLD: begin
        if (cmd_ready) begin
          // A byte in the accepting cycle is treated as if already back in IDLE.
          state_d = (byte_valid && byte_in == SOF) ? S_CMD : S_IDLE;
        end else if (byte_valid) begin
          err_vld_d  = 1'b1;
          err_code_d = ERR_OVERRUN;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A silent cycle at the last count abandons the partial frame.
    if (in_frame && !byte_valid && tmo_q == TMO_LAST) begin
      err_vld_d  = 1'b1;
      err_code_d = ERR_TIMEOUT;
      state_d    = S_IDLE;
      tmo_d      = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      code_q     <= '0;
      len_q      <= '0;
      idx_q      <= '0;
      payload_q  <= '0;
      chk_q      <= '0;
      tmo_q      <= '0;
      err_vld_q  <= 1'b0;
      err_code_q <= 3'd0;
    end else begin
      state_q    <= state_d;
      code_q     <= code_d;
      len_q      <= len_d;
      idx_q      <= idx_d;
      payload_q  <= payload_d;
      chk_q      <= chk_d;
      tmo_q      <= tmo_d;
      err_vld_q  <= err_vld_d;
      err_code_q <= err_code_d;
    end
  end

  assign cmd_valid   = (state_q == S_HOLD);
  assign cmd_code    = code_q;
  assign cmd_len     = len_q;
  assign cmd_payload = payload_q;
  assign err_valid   = err_vld_q;
  assign err_code    = err_code_q;

endmodule

// File: tb/tb_cmd_frame_parser.sv
// Drives directed and random byte streams into cmd_frame_parser and compares every cycle against a frame-level model.
// Latency: model predictions apply to the cycle after the inputs are presented.
// Backpressure: cmd_ready is driven randomly while frames are held.
module tb_cmd_frame_parser;

  localparam int MAX_LEN = 4;
  localparam int TMO     = 50;
  localparam int LEN_W   = $clog2(MAX_LEN + 1);

  logic                 clk = 1'b0;
  logic                 reset;
  logic [7:0]           byte_in;
  logic                 byte_valid;
  logic                 cmd_valid;
  logic                 cmd_ready;
  logic [7:0]           cmd_code;
  logic [LEN_W-1:0]     cmd_len;
  logic [8*MAX_LEN-1:0] cmd_payload;
  logic                 err_valid;
  logic [2:0]           err_code;

  always #5 clk = ~clk;

  cmd_frame_parser #(.MAX_LEN(MAX_LEN), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset), .byte_in(byte_in), .byte_valid(byte_valid),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_code(cmd_code),
    .cmd_len(cmd_len), .cmd_payload(cmd_payload),
    .err_valid(err_valid), .err_code(err_code)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Frame-level reference: bytes after SOF are collected in a queue and judged once enough have arrived.
  bit          m_held;
  bit          m_in_frame;
  logic [7:0]  m_fq[$];
  int          m_idle;
  logic [7:0]  m_code;
  int          m_len;
  logic [31:0] m_pl;
  int          m_err;

  task automatic model_step(input bit bv, input logic [7:0] b, input bit rdy, input bit rst);
    logic [7:0] x;
    int n;
    m_err = 0;
    if (rst) begin
      m_held = 0; m_in_frame = 0; m_fq.delete(); m_idle = 0;
    end else if (m_held) begin
      if (rdy) begin
        m_held = 0;
        if (bv && b == 8'hA5) begin
          m_in_frame = 1; m_fq.delete(); m_idle = 0;
        end
      end else if (bv) begin
        m_err = 4;
      end
    end else if (m_in_frame) begin
      if (bv) begin
        m_fq.push_back(b);
        m_idle = 0;
        n = m_fq.size();
        if (n == 2 && int'(b) > MAX_LEN) begin
          m_err = 2; m_in_frame = 0;
        end else if (n >= 3 && n == int'(m_fq[1]) + 3) begin
          x = 8'h00;
          foreach (m_fq[i]) x = x ^ m_fq[i];
          m_in_frame = 0;
          if (x == 8'h00) begin
            m_held = 1;
            m_code = m_fq[0];
            m_len  = int'(m_fq[1]);
            m_pl   = 32'h0;
            for (int i = 0; i < m_len; i++) m_pl[8*i +: 8] = m_fq[2+i];
          end else begin
            m_err = 1;
          end
        end
      end else if (m_idle == TMO - 1) begin
        m_err = 3; m_in_frame = 0;
      end else begin
        m_idle++;
      end
    end else if (bv && b == 8'hA5) begin
      m_in_frame = 1; m_fq.delete(); m_idle = 0;
    end
  endtask

  task automatic check_outputs();
    chk_eq("cmd_valid", {31'b0, cmd_valid}, {31'b0, m_held});
    chk_eq("err_valid", {31'b0, err_valid}, (m_err != 0) ? 32'd1 : 32'd0);
    chk_eq("err_code", {29'b0, err_code}, m_err);
    if (m_held) begin
      chk_eq("cmd_code", {24'b0, cmd_code}, {24'b0, m_code});
      chk_eq("cmd_len", {{(32-LEN_W){1'b0}}, cmd_len}, m_len);
      chk_eq("cmd_payload", cmd_payload, m_pl);
    end
  endtask

  // One clock: check the state produced by the previous edge, then present new inputs.
  task automatic cyc(input bit bv, input logic [7:0] b, input bit rdy, input bit rst);
    check_outputs();
    reset      = rst;
    byte_valid = bv;
    byte_in    = bv ? b : 8'h00;
    cmd_ready  = rdy;
    model_step(bv, b, rdy, rst);
    @(negedge clk);
  endtask

  task automatic send_seq(input logic [7:0] s[$], input bit rdy);
    foreach (s[i]) cyc(1'b1, s[i], rdy, 1'b0);
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) cyc(1'b0, 8'h00, rdy, 1'b0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk_eq({tag, "_code"}, {24'b0, cmd_code}, 32'h0);
    chk_eq({tag, "_len"}, {{(32-LEN_W){1'b0}}, cmd_len}, 32'h0);
    chk_eq({tag, "_payload"}, cmd_payload, 32'h0);
  endtask

  // Random frame: kind 0 good, 1 bad checksum, 2 oversize LEN, 3 truncated then left to time out.
  task automatic rand_frame();
    logic [7:0] f[$];
    logic [7:0] x;
    int kind, len;
    kind = $urandom_range(0, 9);
    kind = (kind < 6) ? 0 : kind - 6;
    if (kind > 3) kind = 0;
    len = (kind == 2) ? $urandom_range(MAX_LEN + 1, 255) : $urandom_range(0, MAX_LEN);
    f.push_back(8'hA5);
    f.push_back(8'($urandom));
    f.push_back(8'(len));
    if (kind != 2) begin
      for (int i = 0; i < len; i++) f.push_back(8'($urandom));
      x = 8'h00;
      for (int i = 1; i < f.size(); i++) x = x ^ f[i];
      if (kind == 1) x = x ^ 8'($urandom_range(1, 255));
      f.push_back(x);
    end
    if (kind == 3) f = f[0:$urandom_range(1, f.size() - 2)];
    foreach (f[i]) begin
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2), $urandom_range(0, 1) == 1);
      cyc(1'b1, f[i], $urandom_range(0, 1) == 1, 1'b0);
    end
    if (kind == 3) idle(TMO + 3, $urandom_range(0, 1) == 1);
  endtask

  logic [7:0] q[$];

  initial begin
    reset = 1'b1; byte_valid = 1'b0; byte_in = 8'h00; cmd_ready = 1'b0;
    m_held = 0; m_in_frame = 0; m_idle = 0; m_err = 0; m_code = 0; m_len = 0; m_pl = 0;
    @(negedge clk);
    @(negedge clk);
    check_reset_outputs("rst");
    cyc(1'b0, 8'h00, 1'b0, 1'b1);

    // Good frame accepted immediately.
    q = '{8'hA5, 8'h10, 8'h02, 8'h11, 8'h22, 8'h21};
    send_seq(q, 1'b1);
    idle(3, 1'b1);

    // Bad checksum, then a good frame.
    q = '{8'hA5, 8'h10, 8'h02, 8'h11, 8'h22, 8'h20};
    send_seq(q, 1'b1);
    idle(2, 1'b1);
    q = '{8'hA5, 8'h10, 8'h02, 8'h11, 8'h22, 8'h21};
    send_seq(q, 1'b1);
    idle(2, 1'b1);

    // Oversize LEN, trailing bytes ignored.
    q = '{8'hA5, 8'h07, 8'h05, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    send_seq(q, 1'b1);
    idle(2, 1'b1);

    // Timeout after CMD, late bytes ignored.
    q = '{8'hA5, 8'h33};
    send_seq(q, 1'b1);
    idle(TMO + 2, 1'b1);
    q = '{8'h01, 8'h02};
    send_seq(q, 1'b1);
    idle(2, 1'b1);

    // Held frame with overrun bytes, then accepted.
    q = '{8'hA5, 8'h31, 8'h00, 8'h31};
    send_seq(q, 1'b0);
    idle(2, 1'b0);
    q = '{8'h01, 8'h02};
    send_seq(q, 1'b0);
    idle(2, 1'b0);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    idle(2, 1'b1);

    // Reset mid-frame, then a fresh frame.
    q = '{8'hA5, 8'h20, 8'h01};
    send_seq(q, 1'b1);
    cyc(1'b0, 8'h00, 1'b1, 1'b1);
    cyc(1'b0, 8'h00, 1'b1, 1'b1);
    check_reset_outputs("midrst");
    q = '{8'hA5, 8'h20, 8'h01, 8'hAA, 8'h8B};
    send_seq(q, 1'b0);
    idle(1, 1'b0);
    // Byte arriving in the accept cycle is an SOF, no overrun.
    q = '{8'hA5, 8'h44, 8'h00, 8'h44};
    send_seq(q, 1'b1);
    idle(2, 1'b1);

    // Randomized traffic including junk between frames.
    for (int k = 0; k < 300; k++) begin
      if ($urandom_range(0, 4) == 0) cyc(1'b1, 8'($urandom), $urandom_range(0, 1) == 1, 1'b0);
      idle($urandom_range(0, 3), $urandom_range(0, 1) == 1);
      rand_frame();
    end
    idle(TMO + 5, 1'b1);
    check_outputs();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
